rib_rr_arbiter: RTL

RIB_RR_ARBITER -- requirements
Module: rib_rr_arbiter

---
 rtl/rib_rr_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rib_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rib_rr_arbiter
//
// Round-robin arbiter that multiplexes NUM_M bus masters onto one downstream
// slave port. A master owns the port for as long as it keeps its request high.
// On release, ownership passes straight to the next requester in round-robin
// order, or the arbiter returns to IDLE when nobody else is waiting.
//
// Optional feature (compile-time macro RIB_ARB_STARVE_GUARD_EN):
//   When defined, a hold counter forces a rotation after an owner has kept
//   the port for MAX_HOLD contended cycles. When undefined, there is no
//   counter and an owner may hold the port indefinitely.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous reset, active low
//   m_req_i      : per-master request
//   m_we_i       : per-master write enable
//   m_addr_i     : flattened master addresses, master k at [k*AW +: AW]
//   m_data_i     : flattened master write data, master k at [k*DW +: DW]
//   m_data_o     : flattened read data; only the owner's slice is non-zero
//   m_gnt_o      : one-hot grant (all zero when IDLE)
//   hold_flag_o  : some requesting master is currently not granted
//   s_req_o      : downstream request (owner's request while OWNED)
//   s_we_o       : downstream write enable
//   s_addr_o     : downstream address
//   s_data_o     : downstream write data
//   s_data_i     : downstream read data
//   gnt_id_o     : index of the current owner (0 when IDLE)
// -----------------------------------------------------------------------------
module rib_rr_arbiter #(
    parameter int NUM_M    = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           m_req_i,
    input  logic [NUM_M-1:0]           m_we_i,
    input  logic [NUM_M*AW-1:0]        m_addr_i,
    input  logic [NUM_M*DW-1:0]        m_data_i,
    output logic [NUM_M*DW-1:0]        m_data_o,
    output logic [NUM_M-1:0]           m_gnt_o,
    output logic                       hold_flag_o,
    output logic                       s_req_o,
    output logic                       s_we_o,
    output logic [AW-1:0]              s_addr_o,
    output logic [DW-1:0]              s_data_o,
    input  logic [DW-1:0]              s_data_i,
    output logic [$clog2(NUM_M)-1:0]   gnt_id_o
);

    localparam int IDW = $clog2(NUM_M);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   last_q,  last_d;
    logic [NUM_M-1:0] others;
    logic             rotate;
    logic             force_rot;

`ifdef RIB_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
`endif

    // First set bit of req, searching upward from last+1 with wrap-around.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                               input logic [IDW-1:0]   last);
        logic           found;
        logic [IDW-1:0] cand;
        int             idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            idx  = (int'(last) + i) % NUM_M;
            cand = idx[IDW-1:0];
            if (!found && req[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    endfunction

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        others    = m_req_i & ~m_gnt_o;
        force_rot = 1'b0;
        rotate    = 1'b0;
`ifdef RIB_ARB_STARVE_GUARD_EN
        hold_cnt_d = hold_cnt_q;
        force_rot  = (state_q == OWNED) && (|others) &&
                     (hold_cnt_q == CW'(MAX_HOLD - 1));
`endif

        case (state_q)
            IDLE: begin
                if (|m_req_i) begin
                    state_d = OWNED;
                    owner_d = rr_pick(m_req_i, last_q);
                    last_d  = owner_d;
                end
            end
            OWNED: begin
                rotate = !m_req_i[owner_q] || force_rot;
                if (rotate) begin
                    // A newcomer on the same edge the owner drops is already
                    // in 'others', so it takes part in this decision.
                    if (|others) begin
                        owner_d = rr_pick(others, last_q);
                        last_d  = owner_d;
                    end else begin
                        state_d = IDLE;
                    end
`ifdef RIB_ARB_STARVE_GUARD_EN
                    hold_cnt_d = '0;
`endif
                end
`ifdef RIB_ARB_STARVE_GUARD_EN
                else if ((|others) && (hold_cnt_q < CW'(MAX_HOLD - 1))) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDW'(NUM_M - 1);   // master 0 wins first after reset
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef RIB_ARB_STARVE_GUARD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Output routing: everything is derived from state_q, so an asynchronous
    // reset drops the grant and the downstream port without waiting for clk.
    // ---------------------------------------------------------------------
    always_comb begin
        m_gnt_o  = '0;
        gnt_id_o = '0;
        s_req_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        m_data_o = '0;
        if (state_q == OWNED) begin
            m_gnt_o[owner_q]                     = 1'b1;
            gnt_id_o                             = owner_q;
            s_req_o                              = m_req_i[owner_q];
            s_we_o                               = m_we_i[owner_q];
            s_addr_o                             = m_addr_i[int'(owner_q)*AW +: AW];
            s_data_o                             = m_data_i[int'(owner_q)*DW +: DW];
            m_data_o[int'(owner_q)*DW +: DW]     = s_data_i;
        end
    end

    assign hold_flag_o = |(m_req_i & ~m_gnt_o);

endmodule
